fifo_read_ctrl: RTL and testbench
=================================

// Module: fifo_read_ctrl
// PURPOSE
//  Read-domain pointer and empty-flag controller for the async FIFO.
//  Keeps the binary/Gray read pointer, advances it on accepted reads, and drives the RAM read address.
//  Pairs with the direction block: takes the Gray write address and the direction flag; returns the Gray read address.
//  Produces a two-stage-synchronised empty flag, an almost-empty flag and an underflow pulse.
// PARAMETERS
//  DATADEPTH  16  FIFO depth in words; power of two, >= 4; AW = $clog2(DATADEPTH)
//  AE_THRESH  2   almost-empty asserts when level <= AE_THRESH; range 0..DATADEPTH-1
// PORTS
//  r_clk           in   1   read-domain clock; the only clock
//  r_rst           in   1   asynchronous active-low reset, read domain
//  r_en            in   1   read request from consumer
//  G_W_address     in   AW  Gray write address, write-clock domain (asynchronous here)
//  direction       in   1   quadrant direction flag from direction block (1 = going full)
//  R_address       out  AW  binary read address to RAM read port
//  G_R_address     out  AW  registered Gray read address, to direction block and write domain
//  r_empty         out  1   FIFO empty; read requests are ignored while high
//  r_almost_empty  out  1   level <= AE_THRESH, or r_empty
//  r_underflow     out  1   one-cycle pulse: r_en while r_empty
// BEHAVIOUR
//  Reset (r_rst=0, async): R_address=0, G_R_address=0, r_empty=1, r_almost_empty=1,
//   r_underflow=0, both sync stages cleared. Deassertion takes effect on the next r_clk edge.
//  Read accept: rd_ok = r_en & ~r_empty.
//   On an r_clk rising edge with rd_ok: rbin <= rbin+1 (mod DATADEPTH, wraps 15->0 for depth 16);
//   G_R_address <= (rbin+1) ^ ((rbin+1)>>1). Both are registered together.
//   Exactly one Gray bit changes per increment, including on wrap.
//   R_address = rbin. RAM data for the current head is valid while r_empty=0;
//   the consumer samples it on the accept edge (zero-latency head).
//  Empty (Cummings style-2 scheme):
//   aempty = (G_R_address == G_W_address) & ~direction; combinational and asynchronous.
//   Two flops, rempty1 -> r_empty. Both are asynchronously preset to 1 while aempty=1 or r_rst=0.
//   When aempty=0: rempty1 <= 0, then r_empty <= rempty1.
//   Assertion: immediate, the same edge that makes the pointers equal.
//   Deassertion: 2 r_clk edges after aempty falls.
//   The flag never deasserts while aempty=1.
//  Level / almost-empty:
//   G_W_address passes through a 2-flop sync (wg1, wg2, reset 0). wbin_s = gray2bin(wg2).
//   level = (wbin_s - rbin) mod DATADEPTH, AW bits.
//   When level==0 and r_empty=0, level is taken as DATADEPTH (full).
//   r_almost_empty is registered: <= r_empty_next | (level_next <= AE_THRESH).
//   It is conservative (pessimistic by sync latency) and is never low while r_empty=1.
//  Underflow: r_underflow <= r_en & r_empty. Pointer unchanged; no other state is affected.
//  Simultaneous events:
//   A read that empties the FIFO raises r_empty in the same cycle.
//   A write arriving on the same edge keeps r_empty high until the 2-cycle release.
//   r_en held high across empty: accepted on each cycle where r_empty=0 at the edge.
//  Reset mid-operation: all state returns to reset values immediately.
//   The write side must be reset concurrently; no pointer recovery.
// TESTING
//  T1 reset: r_rst=0 mid-stream -> R_address=0, G_R_address=0, r_empty=1, r_almost_empty=1, r_underflow=0 without a clock edge.
//  T2 release: DATADEPTH=16; G_W_address steps 0->1 (gray 0001), direction=0 -> r_empty falls exactly 2 r_clk edges later; r_almost_empty stays 1 (level 1 <= 2).
//  T3 drain: 5 words written, r_en held high -> 5 accepts, R_address 0..4, G_R_address 0,1,3,2,6,7; r_empty=1 on the edge of the 5th accept.
//  T4 wrap: 40 words streamed with write ahead by 3 -> G_R_address 1000 -> 0000 on the 15->0 wrap (single bit change); no spurious r_empty.
//  T5 underflow: r_en=1 while r_empty=1 for 3 cycles -> r_underflow high 3 cycles; R_address unchanged.
//  T6 full: 16 written, direction=1, pointers equal -> r_empty=0, level=16, r_almost_empty=0; reading down to 2 words -> r_almost_empty=1.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// Read-domain pointer, empty and almost-empty controller for the async FIFO.
// Keeps the binary/Gray read pointer and flags empty with the two-flop style-2 scheme.
module fifo_read_ctrl #(
    parameter int DATADEPTH = 16,
    parameter int AE_THRESH = 2,
    localparam int AW = $clog2(DATADEPTH)
) (
    input  logic          r_clk,
    input  logic          r_rst,
    input  logic          r_en,
    input  logic [AW-1:0] G_W_address,
    input  logic          direction,
    output logic [AW-1:0] R_address,
    output logic [AW-1:0] G_R_address,
    output logic          r_empty,
    output logic          r_almost_empty,
    output logic          r_underflow
);

    localparam logic [AW:0] DEPTH_L = DATADEPTH[AW:0];
    localparam logic [AW:0] AE_L    = AE_THRESH[AW:0];

    function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
        logic [AW-1:0] b;
        b[AW-1] = g[AW-1];
        for (int i = AW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [AW-1:0] rbin;
    logic [AW-1:0] rbin_next;
    logic [AW-1:0] rgray_next;
    logic [AW-1:0] wg1;
    logic [AW-1:0] wg2;
    logic [AW-1:0] wbin_s_next;
    logic [AW:0]   level_next;
    logic          rd_ok;
    logic          aempty;
    logic          aempty_next;
    logic          empty_set;
    logic          empty_next;
    logic          rempty1;
    logic          ae_q;

    // Handshake: r_en is a request; a read is accepted (head word consumed,
    // pointer advanced) on every r_clk edge where r_en=1 and r_empty=0.
    // A request while r_empty=1 is dropped and reported on r_underflow.
    always_comb begin
        rd_ok       = r_en & ~r_empty;
        rbin_next   = rbin + {{(AW-1){1'b0}}, rd_ok};
        rgray_next  = rbin_next ^ (rbin_next >> 1);
        aempty      = (G_R_address == G_W_address) & ~direction;
        aempty_next = (rgray_next == G_W_address) & ~direction;
        empty_set   = aempty | ~r_rst;
        empty_next  = rempty1 | aempty_next;
        wbin_s_next = gray2bin(wg1);
        level_next  = {1'b0, wbin_s_next - rbin_next};
        // Equal synchronised pointers with a non-empty FIFO can only mean full.
        if ((level_next == '0) && !empty_next) begin
            level_next = DEPTH_L;
        end
    end

    always_ff @(posedge r_clk or negedge r_rst) begin
        if (!r_rst) begin
            rbin        <= '0;
            G_R_address <= '0;
            wg1         <= '0;
            wg2         <= '0;
            ae_q        <= 1'b1;
            r_underflow <= 1'b0;
        end else begin
            rbin        <= rbin_next;
            G_R_address <= rgray_next;
            wg1         <= G_W_address;
            wg2         <= wg1;
            ae_q        <= empty_next | (level_next <= AE_L);
            r_underflow <= r_en & r_empty;
        end
    end

    // Preset is level-driven by the pointer compare: assertion is immediate,
    // release walks through rempty1 so r_empty falls two edges after aempty.
    always_ff @(posedge r_clk or posedge empty_set) begin
        if (empty_set) begin
            rempty1 <= 1'b1;
            r_empty <= 1'b1;
        end else begin
            rempty1 <= 1'b0;
            r_empty <= rempty1;
        end
    end

    assign R_address      = rbin;
    assign r_almost_empty = ae_q | r_empty;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl (depth 16, almost-empty threshold 2).
// Drives the Gray write pointer and direction flag by hand and checks every flag.
module tb_fifo_read_ctrl;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          r_clk;
    logic          r_rst;
    logic          r_en;
    logic [AW-1:0] G_W_address;
    logic          direction;
    logic [AW-1:0] R_address;
    logic [AW-1:0] G_R_address;
    logic          r_empty;
    logic          r_almost_empty;
    logic          r_underflow;

    int vectors     = 0;
    int miscompares = 0;
    logic [AW-1:0] exp_q[$];

    fifo_read_ctrl #(
        .DATADEPTH(DEPTH),
        .AE_THRESH(2)
    ) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .r_en           (r_en),
        .G_W_address    (G_W_address),
        .direction      (direction),
        .R_address      (R_address),
        .G_R_address    (G_R_address),
        .r_empty        (r_empty),
        .r_almost_empty (r_almost_empty),
        .r_underflow    (r_underflow)
    );

    // clock / reset
    initial begin
        r_clk = 1'b0;
        forever #5 r_clk = ~r_clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] gray(input int b);
        logic [AW-1:0] x;
        x = b[AW-1:0];
        return x ^ (x >> 1);
    endfunction

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic do_reset();
        r_en        = 1'b0;
        G_W_address = '0;
        direction   = 1'b0;
        r_rst       = 1'b0;
        tick();
        tick();
        r_rst = 1'b1;
        tick();
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_raddr"}, R_address, 0);
        check_val({tag, "_graddr"}, G_R_address, 0);
        check_val({tag, "_empty"}, r_empty, 1);
        check_val({tag, "_aempty"}, r_almost_empty, 1);
        check_val({tag, "_uflow"}, r_underflow, 0);
    endtask

    // fills 16 words with the direction flag raised in the last quadrant
    task automatic fill_full();
        for (int w = 1; w <= DEPTH; w++) begin
            G_W_address = gray(w);
            if (w >= 12) direction = 1'b1;
            tick();
        end
        repeat (3) tick();
    endtask

    initial begin
        int wp;
        int rp;

        // reset applied at time zero, no clock edge yet
        r_en        = 1'b0;
        G_W_address = '0;
        direction   = 1'b0;
        r_rst       = 1'b0;
        #1;
        check_reset_vals("t1_init");
        r_rst = 1'b1;
        tick();

        // T2: one write releases empty exactly two edges later
        do_reset();
        G_W_address = gray(1);
        tick();
        check_val("t2_empty_edge1", r_empty, 1);
        tick();
        check_val("t2_empty_edge2", r_empty, 0);
        check_val("t2_aempty", r_almost_empty, 1);

        // T3: drain 5 words with r_en held high
        do_reset();
        for (int w = 1; w <= 5; w++) begin
            G_W_address = gray(w);
            tick();
        end
        repeat (3) tick();
        check_val("t3_pre_empty", r_empty, 0);
        check_val("t3_pre_graddr", G_R_address, 0);
        exp_q = {4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111};
        r_en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            logic [AW-1:0] e;
            tick();
            e = exp_q.pop_front();
            check_val($sformatf("t3_graddr%0d", k), G_R_address, e);
            check_val($sformatf("t3_raddr%0d", k), R_address, k);
            check_val($sformatf("t3_empty%0d", k), r_empty, (k == 5) ? 1 : 0);
        end
        tick();
        check_val("t3_post_uflow", r_underflow, 1);
        check_val("t3_post_raddr", R_address, 5);
        r_en = 1'b0;

        // T4: 40 words streamed with the writer 3 ahead, crossing the wrap twice
        do_reset();
        wp = 0;
        for (int w = 0; w < 3; w++) begin
            wp++;
            G_W_address = gray(wp);
            tick();
        end
        repeat (3) tick();
        check_val("t4_pre_empty", r_empty, 0);
        rp = 0;
        while (rp < 40) begin
            r_en = 1'b1;
            if (wp < 40) begin
                wp++;
                G_W_address = gray(wp);
            end
            tick();
            rp++;
            check_val($sformatf("t4_graddr%0d", rp), G_R_address, gray(rp));
            check_val($sformatf("t4_raddr%0d", rp), R_address, rp % DEPTH);
            check_val($sformatf("t4_empty%0d", rp), r_empty, (rp == wp) ? 1 : 0);
            if (rp == 15) check_val("t4_pre_wrap", G_R_address, 4'b1000);
            if (rp == 16) check_val("t4_wrap", G_R_address, 4'b0000);
        end
        r_en = 1'b0;

        // T5: three underflow requests
        do_reset();
        r_en = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_val($sformatf("t5_uflow%0d", k), r_underflow, 1);
            check_val($sformatf("t5_raddr%0d", k), R_address, 0);
            check_val($sformatf("t5_empty%0d", k), r_empty, 1);
        end
        r_en = 1'b0;
        tick();
        check_val("t5_uflow_clear", r_underflow, 0);

        // T6a + T1: full FIFO, read 5, then reset mid-stream without an edge
        do_reset();
        fill_full();
        check_val("t6a_full_empty", r_empty, 0);
        check_val("t6a_full_aempty", r_almost_empty, 0);
        r_en = 1'b1;
        repeat (5) tick();
        r_en = 1'b0;
        check_val("t6a_raddr", R_address, 5);
        check_val("t6a_graddr", G_R_address, 4'b0111);
        check_val("t6a_aempty", r_almost_empty, 0);
        #2;
        r_rst = 1'b0;
        #1;
        check_reset_vals("t1_mid");
        direction   = 1'b0;
        G_W_address = '0;
        tick();
        r_rst = 1'b1;
        tick();

        // T6b: full FIFO drained down to 2 words
        fill_full();
        check_val("t6b_full_empty", r_empty, 0);
        check_val("t6b_full_aempty", r_almost_empty, 0);
        r_en = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            check_val($sformatf("t6b_aempty%0d", k), r_almost_empty, ((DEPTH - k) <= 2) ? 1 : 0);
            check_val($sformatf("t6b_empty%0d", k), r_empty, 0);
        end
        r_en = 1'b0;
        check_val("t6b_raddr", R_address, 14);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
